fixed_32_dot_accum: RTL and testbench
=====================================

FIXED_32_DOT_ACCUM -- requirements
Module: fixed_32_dot_accum

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning width of the vector-length field.
REQ-002 SHALL have parameter ACC_W, default 40, meaning internal signed accumulator width; ACC_W SHALL be at least 32+LEN_W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begin a new dot product; sampled only in IDLE.
REQ-006 SHALL have port vec_len  input  LEN_W  number of products to sum; latched on accepted start.
REQ-007 SHALL have port p_in  input  32  signed Q24.8 product from the upstream multiplier.
REQ-008 SHALL have port p_ovf  input  1  upstream positive-overflow flag for p_in.
REQ-009 SHALL have port p_udf  input  1  upstream negative-overflow flag for p_in.
REQ-010 SHALL have port in_valid  input  1  p_in, p_ovf and p_udf are valid this cycle.
REQ-011 SHALL have port in_ready  output  1  block accepts a product this cycle.
REQ-012 SHALL have port sum_out  output  32  signed Q24.8 saturated dot-product result.
REQ-013 SHALL have port sat_flag  output  1  result was saturated or an input carried an overflow flag.
REQ-014 SHALL have port out_valid  output  1  sum_out and sat_flag are valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-016 SHALL have port busy  output  1  block is not in IDLE.

Function
REQ-017 SHALL implement states IDLE, ACCUM, DONE; busy = (state != IDLE).
REQ-018 In IDLE, start=1 with vec_len>0: latch vec_len, clear accumulator, count and sticky flag; go to ACCUM next cycle.
REQ-019 In IDLE, start=1 with vec_len=0: go directly to DONE with sum_out=0 and sat_flag=0; out_valid asserts the next cycle.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 in_ready SHALL be 1 only in ACCUM; a beat is accepted when in_valid and in_ready are both 1.
REQ-022 Per accepted beat, the operand SHALL be 0x7FFFFFFF if p_ovf=1, else 0x80000000 if p_udf=1, else p_in. p_ovf has priority if both flags are set.
REQ-023 The operand SHALL be sign-extended to ACC_W and added to the accumulator; no wrap is possible within 2^LEN_W-1 beats.
REQ-024 Any accepted beat with p_ovf or p_udf set SHALL set the sticky flag.
REQ-025 A counter SHALL increment per accepted beat; the beat that brings the count to the latched vec_len SHALL move the state to DONE.
REQ-026 Entering DONE, sum_out SHALL be registered as the accumulator clamped to [0x80000000, 0x7FFFFFFF].
REQ-027 Entering DONE, sat_flag SHALL be registered as sticky OR clamp-occurred.
REQ-028 Latency: out_valid SHALL assert the cycle after the last beat is accepted.
REQ-029 In DONE, out_valid=1 and sum_out and sat_flag SHALL hold stable until out_ready=1; the handshake cycle returns the state to IDLE.
REQ-030 A new start SHALL be accepted no earlier than the cycle after the handshake, when the state is IDLE.
REQ-031 Gaps in in_valid SHALL stall accumulation without losing state; p_in is ignored while in_ready=0.
REQ-032 Fixed-point scaling is unchanged: the sum of Q24.8 values is Q24.8, with no shift.

Reset
REQ-033 On rst=1 at a clock edge, the following SHALL take effect from any state, including mid-ACCUM:
- state=IDLE
- accumulator=0, count=0, sticky flag=0
- sum_out=0, sat_flag=0, out_valid=0, in_ready=0, busy=0
REQ-034 Reset SHALL dominate start and all handshakes in the same cycle; a partial sum is discarded.

Verification
REQ-035 vec_len=3, p_in=0x00000100, 0x00000200, 0xFFFFFF00 -> sum_out=0x00000200, sat_flag=0, out_valid exactly 1 cycle after the 3rd beat.
REQ-036 vec_len=2, p_in=0x7FFFFFFF twice -> sum_out=0x7FFFFFFF, sat_flag=1; repeat with 0x80000000 twice -> sum_out=0x80000000, sat_flag=1.
REQ-037 vec_len=2, beat1 p_in=0x100 with p_ovf=1, beat2 p_in=0x80000000 -> operands 0x7FFFFFFF and 0x80000000, sum_out=0xFFFFFFFF, sat_flag=1.
REQ-038 vec_len=0 with start -> out_valid next cycle, sum_out=0, sat_flag=0, in_ready never asserts.
REQ-039 vec_len=4 with in_valid gaps and out_ready held low 5 cycles -> correct sum; out_valid and sum_out stable throughout; IDLE after the handshake; start during DONE ignored.
REQ-040 rst after 2 of 4 beats -> all outputs 0 next cycle; a subsequent vec_len=1, p_in=0x300 run -> sum_out=0x00000300.

Source files
------------

// File: rtl/fixed_32_dot_accum_if.sv
// Product-in / result-out bundle for the Q24.8 dot-product accumulator.
// The master side drives products and consumes results; the slave side is the accumulator.
interface fixed_32_dot_accum_if #(
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] vec_len;
   logic [31:0]      p_in;
   logic             p_ovf;
   logic             p_udf;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      sum_out;
   logic             sat_flag;
   logic             out_valid;
   logic             out_ready;
   logic             busy;

   modport master (
      output start, vec_len, p_in, p_ovf, p_udf, in_valid, out_ready,
      input  in_ready, sum_out, sat_flag, out_valid, busy
   );

   modport slave (
      input  start, vec_len, p_in, p_ovf, p_udf, in_valid, out_ready,
      output in_ready, sum_out, sat_flag, out_valid, busy
   );
endinterface

// File: rtl/fixed_32_dot_accum.sv
// Sums vec_len signed Q24.8 products into a saturated Q24.8 result; out_valid one cycle after the last beat.
// Inputs are taken only in ACCUM (in_valid gaps stall); the result holds in DONE until out_ready.
module fixed_32_dot_accum #(
   parameter int LEN_W = 8,
   parameter int ACC_W = 40
) (
   input logic                  clk,
   input logic                  rst,
   fixed_32_dot_accum_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-32){1'b0}}, 32'h7FFF_FFFF};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-32){1'b1}}, 32'h8000_0000};

   state_t                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d, acc_sum;
   logic [LEN_W-1:0]         cnt_q, cnt_d, len_q, len_d, cnt_inc;
   logic                     sticky_q, sticky_d, sat_q, sat_d;
   logic [31:0]              sum_q, sum_d, op32, sum_clamped;
   logic                     beat, flag_in, clamp_hi, clamp_lo;

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.sum_out   = sum_q;
   assign bus.sat_flag  = sat_q;

   assign beat    = bus.in_valid && (state_q == ACCUM);
   assign flag_in = bus.p_ovf || bus.p_udf;
   assign cnt_inc = cnt_q + LEN_W'(1);

   // Overflow flag wins over underflow when both are raised.
   always_comb begin
      op32 = bus.p_in;
      if (bus.p_ovf) begin
         op32 = 32'h7FFF_FFFF;
      end else if (bus.p_udf) begin
         op32 = 32'h8000_0000;
      end
   end

   assign acc_sum  = acc_q + {{(ACC_W-32){op32[31]}}, op32};
   assign clamp_hi = (acc_sum > MAX_V);
   assign clamp_lo = (acc_sum < MIN_V);

   always_comb begin
      sum_clamped = acc_sum[31:0];
      if (clamp_hi) begin
         sum_clamped = 32'h7FFF_FFFF;
      end else if (clamp_lo) begin
         sum_clamped = 32'h8000_0000;
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      len_d    = len_q;
      sticky_d = sticky_q;
      sum_d    = sum_q;
      sat_d    = sat_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               acc_d    = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               len_d    = bus.vec_len;
               if (bus.vec_len == '0) begin
                  sum_d   = '0;
                  sat_d   = 1'b0;
                  state_d = DONE;
               end else begin
                  state_d = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_d    = acc_sum;
               cnt_d    = cnt_inc;
               sticky_d = sticky_q || flag_in;
               if (cnt_inc == len_q) begin
                  sum_d   = sum_clamped;
                  sat_d   = sticky_q || flag_in || clamp_hi || clamp_lo;
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         len_q    <= '0;
         sticky_q <= 1'b0;
         sum_q    <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         len_q    <= len_d;
         sticky_q <= sticky_d;
         sum_q    <= sum_d;
         sat_q    <= sat_d;
      end
   end

endmodule

// File: tb/tb_fixed_32_dot_accum.sv
// Directed bench for fixed_32_dot_accum: expected results are queued at start, a monitor checks them at handshake.
module tb_fixed_32_dot_accum;

   typedef struct packed {
      logic [31:0] sum;
      logic        sat;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_err;
   exp_t exp_q[$];

   logic        hold_q;
   logic [31:0] hold_sum;
   logic        hold_sat;

   fixed_32_dot_accum_if #(.LEN_W(8)) bus ();

   fixed_32_dot_accum #(.LEN_W(8), .ACC_W(40)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic do_start(input logic [7:0] len, input logic [31:0] e_sum, input logic e_sat);
      exp_t e;
      e.sum = e_sum;
      e.sat = e_sat;
      exp_q.push_back(e);
      bus.start   = 1'b1;
      bus.vec_len = len;
      @(posedge clk); #1;
      bus.start   = 1'b0;
   endtask

   task automatic beat(input logic [31:0] p, input logic o, input logic u);
      bit ok;
      ok = 1'b0;
      bus.p_in     = p;
      bus.p_ovf    = o;
      bus.p_udf    = u;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_err++;
         $display("FAIL beat_ready: got in_ready=0 want 1 within 20 cycles");
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.p_in     = 32'hDEAD_BEEF;
      bus.p_ovf    = 1'b0;
      bus.p_udf    = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, {31'd0, ok}, 32'd1);
   endtask

   // Scoreboard monitor: pops on every result handshake and watches for changes while stalled.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q) begin
            chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("hold_sum", bus.sum_out, hold_sum);
            chk("hold_sat", {31'd0, bus.sat_flag}, {31'd0, hold_sat});
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_result: got sum=%h with no result outstanding", bus.sum_out);
            end else begin
               e = exp_q.pop_front();
               chk("sum_out", bus.sum_out, e.sum);
               chk("sat_flag", {31'd0, bus.sat_flag}, {31'd0, e.sat});
            end
         end
         hold_q   = bus.out_valid && !bus.out_ready;
         hold_sum = bus.sum_out;
         hold_sat = bus.sat_flag;
      end
   end

   initial begin
      n_checks     = 0;
      n_err        = 0;
      hold_q       = 1'b0;
      hold_sum     = '0;
      hold_sat     = 1'b0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.vec_len  = '0;
      bus.p_in     = 32'hDEAD_BEEF;
      bus.p_ovf    = 1'b0;
      bus.p_udf    = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_sum", bus.sum_out, 32'h0);
      chk("rst_sat", {31'd0, bus.sat_flag}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 0x100 + 0x200 - 0x100 = 0x200
      do_start(8'd3, 32'h0000_0200, 1'b0);
      chk("accum_in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("accum_busy", {31'd0, bus.busy}, 32'd1);
      beat(32'h0000_0100, 1'b0, 1'b0);
      beat(32'h0000_0200, 1'b0, 1'b0);
      chk("early_out_valid", {31'd0, bus.out_valid}, 32'd0);
      beat(32'hFFFF_FF00, 1'b0, 1'b0);
      chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
      wait_idle("idle_t1");

      // Positive and negative clamp
      do_start(8'd2, 32'h7FFF_FFFF, 1'b1);
      beat(32'h7FFF_FFFF, 1'b0, 1'b0);
      beat(32'h7FFF_FFFF, 1'b0, 1'b0);
      wait_idle("idle_t2");
      do_start(8'd2, 32'h8000_0000, 1'b1);
      beat(32'h8000_0000, 1'b0, 1'b0);
      beat(32'h8000_0000, 1'b0, 1'b0);
      wait_idle("idle_t3");

      // Flag substitution: 0x7FFFFFFF + 0x80000000 = -1, sticky from p_ovf
      do_start(8'd2, 32'hFFFF_FFFF, 1'b1);
      beat(32'h0000_0100, 1'b1, 1'b0);
      beat(32'h8000_0000, 1'b0, 1'b0);
      wait_idle("idle_t4");

      // Both flags: p_ovf wins -> 0x7FFFFFFF + 0x100 clamps high
      do_start(8'd2, 32'h7FFF_FFFF, 1'b1);
      beat(32'h0000_0000, 1'b1, 1'b1);
      beat(32'h0000_0100, 1'b0, 1'b0);
      wait_idle("idle_t5");

      // Zero-length vector
      do_start(8'd0, 32'h0, 1'b0);
      chk("len0_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("len0_in_ready", {31'd0, bus.in_ready}, 32'd0);
      wait_idle("idle_t6");

      // Gaps with junk and flags on the bus, stalled consumer, start ignored in DONE.
      // 0x1000 - 0x800 + 0x80 + 0x20 = 0x8A0
      do_start(8'd4, 32'h0000_08A0, 1'b0);
      bus.p_ovf = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      beat(32'h0000_1000, 1'b0, 1'b0);
      bus.p_udf = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      beat(32'hFFFF_F800, 1'b0, 1'b0);
      beat(32'h0000_0080, 1'b0, 1'b0);
      bus.out_ready = 1'b0;
      @(posedge clk); #1;
      beat(32'h0000_0020, 1'b0, 1'b0);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      bus.start   = 1'b1;
      bus.vec_len = 8'd1;
      @(posedge clk); #1;
      bus.start   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      chk("post_hs_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("done_start_ignored", {31'd0, bus.busy}, 32'd0);

      // Reset mid-accumulation dominates a simultaneous start
      do_start(8'd4, 32'h0, 1'b0);
      beat(32'h0000_0100, 1'b1, 1'b0);
      beat(32'h0000_0100, 1'b0, 1'b0);
      void'(exp_q.pop_back());
      rst         = 1'b1;
      bus.start   = 1'b1;
      bus.vec_len = 8'd1;
      @(posedge clk); #1;
      rst       = 1'b0;
      bus.start = 1'b0;
      chk("mid_rst_sum", bus.sum_out, 32'h0);
      chk("mid_rst_sat", {31'd0, bus.sat_flag}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      do_start(8'd1, 32'h0000_0300, 1'b0);
      beat(32'h0000_0300, 1'b0, 1'b0);
      wait_idle("idle_t8");

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
